// File: rtl/tc_decoder_pkg.sv
// -----------------------------------------------------------------------------
// tc_decoder_pkg
// Shared types and helpers for the tc_decoder_seq family.
//   mode_t  : operating mode encoding (DECODE, THERMO, SCAN, RSVD)
//   state_t : scan sequencer state (IDLE, RUN)
//   onehot(idx) / thermo(idx) : index decode helpers.
// The helpers work on the widest supported select (MAX_SEL_W). Callers
// zero-extend their SEL_W index and size-cast the result down to 2**SEL_W,
// so one function body serves every SEL_W up to MAX_SEL_W.
// -----------------------------------------------------------------------------
package tc_decoder_pkg;

   localparam int MAX_SEL_W = 8;
   localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

   typedef enum logic [1:0] {
      DECODE = 2'b00,
      THERMO = 2'b01,
      SCAN   = 2'b10,
      RSVD   = 2'b11
   } mode_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Single set bit at position idx.
   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
      return {{(MAX_OUT_W-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Bits 0..idx set. Evaluated one bit wider than the output so that the
   // all-ones index produces all-ones instead of overflowing to zero.
   function automatic logic [MAX_OUT_W-1:0] thermo(input logic [MAX_SEL_W-1:0] idx);
      return MAX_OUT_W'(({{MAX_OUT_W{1'b0}}, 1'b1}
                         << ({1'b0, idx} + {{MAX_SEL_W{1'b0}}, 1'b1}))
                        - {{MAX_OUT_W{1'b0}}, 1'b1});
   endfunction

endpackage

// File: rtl/tc_decoder_comb.sv
// -----------------------------------------------------------------------------
// tc_decoder_comb
// Purely combinational index decode: one-hot and thermometer views of idx.
// Ports:
//   idx         in  SEL_W      index to decode
//   onehot_vec  out 2**SEL_W   1 << idx
//   thermo_vec  out 2**SEL_W   bits 0..idx set
// SEL_W must not exceed tc_decoder_pkg::MAX_SEL_W.
// -----------------------------------------------------------------------------
module tc_decoder_comb
   import tc_decoder_pkg::*;
#(
   parameter int SEL_W = 2
) (
   input  logic [SEL_W-1:0]    idx,
   output logic [2**SEL_W-1:0] onehot_vec,
   output logic [2**SEL_W-1:0] thermo_vec
);

   localparam int OUT_W = 2 ** SEL_W;

   // Widen the index to the helper width and narrow the result back.
   always_comb begin
      onehot_vec = OUT_W'(onehot(MAX_SEL_W'(idx)));
      thermo_vec = OUT_W'(thermo(MAX_SEL_W'(idx)));
   end

endmodule

// File: rtl/tc_decoder_seq.sv
// -----------------------------------------------------------------------------
// tc_decoder_seq
// Registered N-to-2^N decoder with one-hot, thermometer and self-timed scan
// modes. All outputs except busy come straight from flops.
// Ports:
//   clk    in   1          clock
//   rst_n  in   1          synchronous active-low reset
//   en     in   1          advance enable; low holds every output
//   mode   in   2          00 DECODE, 01 THERMO, 10 SCAN, 11 reserved
//   sel    in   SEL_W      decode index / last scan index
//   start  in   1          scan start, honoured in IDLE with mode SCAN
//   out    out  2**SEL_W   registered decoded lines
//   valid  out  1          out holds a current result
//   busy   out  1          scan in progress (decode of state RUN)
//   done   out  1          one-cycle pulse when a scan completes
// -----------------------------------------------------------------------------
module tc_decoder_seq
   import tc_decoder_pkg::*;
#(
   parameter int SEL_W = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic [SEL_W-1:0]    sel,
   input  logic                start,
   output logic [2**SEL_W-1:0] out,
   output logic                valid,
   output logic                busy,
   output logic                done
);

   localparam int OUT_W = 2 ** SEL_W;

   state_t             state_r, state_n;
   logic [SEL_W-1:0]   ptr_r, ptr_n;
   logic [SEL_W-1:0]   last_r, last_n;
   logic [OUT_W-1:0]   out_r, out_n;
   logic               valid_r, valid_n;
   logic               done_r, done_n;

   mode_t              mode_s;
   logic [SEL_W-1:0]   ptr_inc_s;
   logic [SEL_W-1:0]   idx_s;
   logic [OUT_W-1:0]   onehot_s;
   logic [OUT_W-1:0]   thermo_s;

   // Index mux feeding the single shared decoder: sel while idle, the next
   // scan position while running. ptr+1 may wrap when ptr==last==OUT_W-1,
   // but that value is not used because the scan ends instead.
   always_comb begin
      mode_s    = mode_t'(mode);
      ptr_inc_s = ptr_r + SEL_W'(1);
      if (state_r == RUN) begin
         idx_s = ptr_inc_s;
      end else begin
         idx_s = sel;
      end
   end

   tc_decoder_comb #(
      .SEL_W (SEL_W)
   ) u_comb (
      .idx        (idx_s),
      .onehot_vec (onehot_s),
      .thermo_vec (thermo_s)
   );

   // Next-state and next-output logic; everything holds unless en is high.
   always_comb begin
      state_n = state_r;
      ptr_n   = ptr_r;
      last_n  = last_r;
      out_n   = out_r;
      valid_n = valid_r;
      done_n  = 1'b0;
      if (en) begin
         case (state_r)
            IDLE: begin
               case (mode_s)
                  DECODE: begin
                     out_n   = onehot_s;
                     valid_n = 1'b1;
                  end
                  THERMO: begin
                     out_n   = thermo_s;
                     valid_n = 1'b1;
                  end
                  SCAN: begin
                     if (start) begin
                        last_n  = sel;
                        ptr_n   = '0;
                        out_n   = OUT_W'(1);
                        valid_n = 1'b1;
                        state_n = RUN;
                     end else begin
                        valid_n = 1'b0;
                     end
                  end
                  RSVD: begin
                     valid_n = 1'b0;
                  end
                  default: begin
                     valid_n = 1'b0;
                  end
               endcase
            end
            RUN: begin
               // mode, sel and start are deliberately not looked at here.
               if (ptr_r != last_r) begin
                  ptr_n = ptr_inc_s;
                  out_n = onehot_s;
               end else begin
                  out_n   = '0;
                  valid_n = 1'b0;
                  done_n  = 1'b1;
                  state_n = IDLE;
               end
            end
            default: begin
               state_n = IDLE;
               out_n   = '0;
               valid_n = 1'b0;
            end
         endcase
      end else begin
         done_n = 1'b0;
      end
   end

   // State and output registers; reset also aborts a running scan silently.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         ptr_r   <= '0;
         last_r  <= '0;
         out_r   <= '0;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         ptr_r   <= ptr_n;
         last_r  <= last_n;
         out_r   <= out_n;
         valid_r <= valid_n;
         done_r  <= done_n;
      end
   end

   assign out   = out_r;
   assign valid = valid_r;
   assign done  = done_r;
   assign busy  = (state_r == RUN);

endmodule

// File: doc/tc_decoder_seq.md
# tc_decoder_seq

Parametrised, registered N-to-2^N decoder, the next generation of the fixed 2-to-4 decoder in the TC component library. It provides three output modes: one-hot decode, thermometer decode, and a self-timed scan that walks a one-hot bit from output 0 up to a selected index. It sits between control logic and banks of enable/select lines, for example register-file write enables, and drives them from flops rather than combinationally.

## Interface
Parameters:
- SEL_W, default 2: select width.
- OUT_W (localparam, = 2**SEL_W): output width. Not overridable.

Ports:
- clk  input  1  clock. Single clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  advance enable. Low stalls the block: outputs hold.
- mode  input  2  operating mode: 00 DECODE, 01 THERMO, 10 SCAN, 11 reserved.
- sel  input  SEL_W  decode index, or last index for SCAN.
- start  input  1  SCAN start pulse. Honoured only in IDLE with mode==SCAN.
- out  output  OUT_W  registered decoded lines.
- valid  output  1  out holds a current result.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse at scan completion.

## Operation
- Internal state is the enum {IDLE, RUN}. Registers: state, ptr[SEL_W], last[SEL_W], out, valid, done.
- Reset (rst_n==0 at a clk edge): state=IDLE, ptr=0, last=0, out=0, valid=0, busy=0, done=0. Reset overrides all other inputs, including an active scan; done is not emitted for an aborted scan.

IDLE behaviour, evaluated each edge:
- en==0: out and valid hold; done=0.
- DECODE: out <= 1<<sel; valid <= 1.
- THERMO: out <= (2<<sel)-1, so bits 0..sel are set. sel=all-ones gives out all-ones; compute in OUT_W+1 bits and truncate.
- SCAN, start==0: out holds; valid <= 0.
- SCAN, start==1: last <= sel; ptr <= 0; out <= 1; valid <= 1; state -> RUN. start is sampled only when en==1.
- mode 11: out holds; valid <= 0.

RUN behaviour:
- mode, sel and start are ignored while in RUN. mode is re-sampled only in IDLE.
- en==0: stall. out, ptr and valid hold.
- en==1, ptr!=last: ptr <= ptr+1; out <= 1<<(ptr+1).
- en==1, ptr==last: out <= 0; valid <= 0; done <= 1 for one cycle; state -> IDLE.
- busy is the combinational decode of state==RUN. It is the only non-flop output.
- The next start is accepted in the cycle where done==1, because state is already IDLE. Back-to-back scans are therefore legal with no gap cycle.
- At most one bit of out is set in DECODE and SCAN.
- ptr never wraps: RUN exits at last, and last <= OUT_W-1.

## Timing
- DECODE/THERMO latency: 1 cycle, from sel/mode sampled at edge k to out/valid at edge k+1.
- SCAN with last=L and no stalls:
  - Start sampled at edge 0.
  - out=1<<i during cycle i+1, for i=0..L.
  - done=1, out=0 and busy=0 in cycle L+2.
  - Total L+2 cycles from start to done.
- A stall adds exactly one cycle per en==0 cycle in RUN.
- sel=0 SCAN: out=1 for one cycle, then done.

## Structure
- Shared package tc_decoder_pkg holds:
  - the mode_t enum (DECODE, THERMO, SCAN, RSVD);
  - the state_t enum (IDLE, RUN);
  - the helper functions onehot(idx) and thermo(idx), parametrised via SEL_W.
- One sub-module, tc_decoder_comb, provides the pure combinational index-to-one-hot/thermometer decode. It is instantiated once, with the index mux selecting sel in IDLE and ptr+1 in RUN.
- Expected size: roughly 150–250 lines of RTL.

## Test plan
- Reset then DECODE: SEL_W=3, mode=00, sel=5, en=1 → next cycle out=8'b0010_0000, valid=1; sel=0 → out=8'b0000_0001.
- THERMO boundaries: SEL_W=3, sel=0 → out=8'h01; sel=7 → out=8'hFF; sel=3 → out=8'h0F.
- SCAN no stall: SEL_W=2, sel=2, start at cycle 0 → out=0001/0010/0100 in cycles 1–3 with busy=1; cycle 4 has out=0, done=1, busy=0.
- SCAN with stall and ignored inputs: deassert en in cycle 2 while changing mode to DECODE and pulsing start → out stays 0010 for 2 cycles; done is delayed by 1 cycle; mode and start have no effect.
- Back-to-back scans: assert start in the done cycle with sel=0 → out=0001 the next cycle, then done again.
- Reset mid-scan: drive rst_n=0 in cycle 2 of an L=3 scan → next cycle out=0, valid=0, busy=0, done=0; done never pulses.
